pwm_array: RTL and testbench

PWM_ARRAY -- requirements
Module: pwm_array

---
 rtl/pwm_array_pkg.sv | 23 ++
 rtl/pwm_array_if.sv | 25 ++
 rtl/pwm_array_timebase.sv | 74 +++++++
 rtl/pwm_array.sv | 108 ++++++++++
 tb/tb_pwm_array.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_array_pkg.sv
// Shared types and reset defaults for the PWM array.
//   mode_e : counter shape (EDGE = saw-tooth, CENTER = triangle)
//   dir_e  : counting direction in centre-aligned mode
//   RST_*  : configuration loaded by reset into both the active and the pending set
package pwm_array_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  localparam mode_e       RST_MODE     = EDGE;
  localparam int unsigned RST_DUTY     = 0;
  localparam int unsigned RST_PRESCALE = 0;
  // The reset period is all ones; it is written as '1 at the point of use
  // because its width depends on the instance.

endpackage

// File: rtl/pwm_array_if.sv
// Bus between the PWM array's shadow/compare logic and its timebase.
//   period, prescale, mode : active configuration (driven by the master)
//   cnt                    : current counter value
//   boundary               : high in the cycle whose tick ends the period
//   period_tick            : registered one-clock pulse as the counter restarts
interface pwm_array_if
  import pwm_array_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
);

  logic [CNT_W-1:0] period;
  logic [PRE_W-1:0] prescale;
  mode_e            mode;
  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic             period_tick;

  modport master (output period, prescale, mode,
                  input  cnt, boundary, period_tick);
  modport slave  (input  period, prescale, mode,
                  output cnt, boundary, period_tick);

endinterface

// File: rtl/pwm_array_timebase.sv
// Prescaler, up/up-down counter and period boundary detection.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side; takes active period/prescale/mode, returns
//              cnt, boundary (combinational) and period_tick (registered)
module pwm_array_timebase
  import pwm_array_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input logic       clk,
  input logic       rst,
  pwm_array_if.slave bus
);

  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  dir_e             dir;
  logic             tick;
  logic             at_top;
  logic             boundary;
  logic             period_tick;

  // NOTE: every signal assigned in always_comb gets a default before any
  // branch so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick     = (pre == bus.prescale);
    at_top   = (cnt == bus.period);
    boundary = 1'b0;
    if (tick) begin
      if (bus.period == '0)
        boundary = 1'b1;
      else if (bus.mode == EDGE)
        boundary = at_top;
      else if (dir == DOWN)
        boundary = (cnt == CNT_W'(1));
      else
        // With P == 1 the down leg P-1..1 is empty, so the top ends the period.
        boundary = at_top && (bus.period == CNT_W'(1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      cnt         <= '0;
      dir         <= UP;
      period_tick <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + PRE_W'(1);
      period_tick <= boundary;
      if (boundary) begin
        cnt <= '0;
        dir <= UP;
      end else if (tick) begin
        if (bus.mode == EDGE || dir == DOWN) begin
          cnt <= (bus.mode == EDGE) ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
        end else if (at_top) begin
          dir <= DOWN;
          cnt <= cnt - CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.cnt         = cnt;
  assign bus.boundary    = boundary;
  assign bus.period_tick = period_tick;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM generator sharing one timebase.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   out_en        : per-channel enable (0 forces the output low)
//   pwm_en        : per-channel PWM mode (0 = static high when enabled)
//   duty          : packed duties, channel i at [i*CNT_W +: CNT_W]
//   period        : counter terminal value P
//   prescale      : counter advances every prescale+1 clocks
//   center_mode   : 0 = edge-aligned, 1 = center-aligned
//   cfg_valid     : strobe capturing duty/period/prescale/center_mode
//   out           : registered channel outputs
//   period_tick   : one-clock pulse as each period starts
//   cfg_pending   : captured config waiting for the next boundary
// Captured config is shadowed and only becomes active at a period boundary,
// so a period never mixes old and new settings. Enables act immediately.
module pwm_array
  import pwm_array_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       out_en,
  input  logic [N_CH-1:0]       pwm_en,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [CNT_W-1:0]      period,
  input  logic [PRE_W-1:0]      prescale,
  input  logic                  center_mode,
  input  logic                  cfg_valid,
  output logic [N_CH-1:0]       out,
  output logic                  period_tick,
  output logic                  cfg_pending
);

  logic [N_CH*CNT_W-1:0] duty_act,   duty_pnd;
  logic [CNT_W-1:0]      period_act, period_pnd;
  logic [PRE_W-1:0]      pre_act,    pre_pnd;
  mode_e                 mode_act,   mode_pnd;
  mode_e                 mode_in;
  logic [N_CH-1:0]       out_next;

  pwm_array_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) tbus ();

  assign tbus.period   = period_act;
  assign tbus.prescale = pre_act;
  assign tbus.mode     = mode_act;
  assign mode_in       = center_mode ? CENTER : EDGE;

  pwm_array_timebase #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_timebase (
    .clk (clk),
    .rst (rst),
    .bus (tbus.slave)
  );

  // NOTE: the config registers are reset explicitly because a reset must
  // leave a known, runnable configuration in both the active and shadow set.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_act    <= {N_CH{CNT_W'(RST_DUTY)}};
      duty_pnd    <= {N_CH{CNT_W'(RST_DUTY)}};
      period_act  <= '1;
      period_pnd  <= '1;
      pre_act     <= PRE_W'(RST_PRESCALE);
      pre_pnd     <= PRE_W'(RST_PRESCALE);
      mode_act    <= RST_MODE;
      mode_pnd    <= RST_MODE;
      cfg_pending <= 1'b0;
    end else if (cfg_valid) begin
      duty_pnd   <= duty;
      period_pnd <= period;
      pre_pnd    <= prescale;
      mode_pnd   <= mode_in;
      if (tbus.boundary) begin
        // A write landing on the boundary itself bypasses the shadow.
        duty_act    <= duty;
        period_act  <= period;
        pre_act     <= prescale;
        mode_act    <= mode_in;
        cfg_pending <= 1'b0;
      end else begin
        cfg_pending <= 1'b1;
      end
    end else if (tbus.boundary && cfg_pending) begin
      duty_act    <= duty_pnd;
      period_act  <= period_pnd;
      pre_act     <= pre_pnd;
      mode_act    <= mode_pnd;
      cfg_pending <= 1'b0;
    end
  end

  always_comb begin
    out_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (out_en[i])
        out_next[i] = pwm_en[i] ? (tbus.cnt < duty_act[i*CNT_W +: CNT_W]) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= out_next;
  end

  assign period_tick = tbus.period_tick;

endmodule

// File: tb/tb_pwm_array.sv
// Self-checking bench for pwm_array (N_CH=16, CNT_W=8, PRE_W=8).
// A reference model describes each period as a list of counter values, each
// held prescale+1 clocks, and predicts out/period_tick/cfg_pending every clock.
module tb_pwm_array;

  localparam int N_CH  = 16;
  localparam int CNT_W = 8;
  localparam int PRE_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       out_en, pwm_en;
  logic [N_CH*CNT_W-1:0] duty;
  logic [CNT_W-1:0]      period;
  logic [PRE_W-1:0]      prescale;
  logic                  center_mode, cfg_valid;
  logic [N_CH-1:0]       out;
  logic                  period_tick, cfg_pending;

  always #5 clk = ~clk;

  pwm_array #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .out_en      (out_en),
    .pwm_en      (pwm_en),
    .duty        (duty),
    .period      (period),
    .prescale    (prescale),
    .center_mode (center_mode),
    .cfg_valid   (cfg_valid),
    .out         (out),
    .period_tick (period_tick),
    .cfg_pending (cfg_pending)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_duty[N_CH], p_duty[N_CH];
  int              m_per, p_per, m_ps, p_ps;
  bit              m_ctr, p_ctr, m_pend, m_ptick;
  int              t;  // clocks elapsed in the current period
  logic [N_CH-1:0] m_out;

  // Number of counter values in one period.
  function automatic int seq_len(input int p, input bit ctr);
    if (p == 0) return 1;
    return ctr ? 2 * p : p + 1;
  endfunction

  // Counter value at position k of the period (rising to p, then falling).
  function automatic int seq_val(input int k, input int p);
    return (k <= p) ? k : 2 * p - k;
  endfunction

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    int len, cnt;
    bit bnd;
    if (rst) begin
      m_out = '0; m_ptick = 0; m_pend = 0; t = 0;
      m_per = 255; p_per = 255; m_ps = 0; p_ps = 0; m_ctr = 0; p_ctr = 0;
      for (int c = 0; c < N_CH; c++) begin m_duty[c] = 0; p_duty[c] = 0; end
    end else begin
      len = seq_len(m_per, m_ctr) * (m_ps + 1);
      cnt = seq_val(t / (m_ps + 1), m_per);
      bnd = (t == len - 1);
      for (int c = 0; c < N_CH; c++)
        m_out[c] = !out_en[c] ? 1'b0 : !pwm_en[c] ? 1'b1 : (cnt < m_duty[c]);
      m_ptick = bnd;
      if (cfg_valid) begin
        for (int c = 0; c < N_CH; c++) p_duty[c] = int'(duty[c*CNT_W +: CNT_W]);
        p_per = int'(period); p_ps = int'(prescale); p_ctr = center_mode;
      end
      if (bnd && (cfg_valid || m_pend)) begin
        m_duty = p_duty; m_per = p_per; m_ps = p_ps; m_ctr = p_ctr;
        m_pend = 0;
      end else if (cfg_valid) begin
        m_pend = 1;
      end
      t = bnd ? 0 : t + 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("out", 32'(out), 32'(m_out));
    check("period_tick", 32'(period_tick), 32'(m_ptick));
    check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
  endtask

  task automatic set_cfg(input int per, input int ps, input bit ctr, input int d0);
    period      = CNT_W'(per);
    prescale    = PRE_W'(ps);
    center_mode = ctr;
    duty[0 +: CNT_W] = CNT_W'(d0);
    cfg_valid   = 1'b1;
    cycle();
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (period_tick) seen = 1;
    end
    check("tick_seen", 32'(seen), 32'd1);
  endtask

  task automatic count_run(input int n, output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      highs += int'(out[0]);
      ticks += int'(period_tick);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int h, tk;
    rst = 1'b1; out_en = '1; pwm_en = '0; duty = '0; period = '0;
    prescale = '0; center_mode = 1'b0; cfg_valid = 1'b0;

    // Reset for two clocks, then static-high outputs one clock after release.
    cycle(); check("rst_out_a", 32'(out), 32'd0);
    cycle(); check("rst_out_b", 32'(out), 32'd0);
    rst = 1'b0;
    cycle(); check("release_out", 32'(out), 32'hFFFF);

    // Edge mode, P=9, duty0=3: 3 of 10 high, tick every 10.
    pwm_en = '1;
    for (int c = 1; c < N_CH; c++) duty[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
    set_cfg(9, 0, 0, 3);
    wait_tick(400); cycle();
    count_run(30, h, tk);
    check("edge_d3_highs", 32'(h), 32'd9);
    check("edge_d3_ticks", 32'(tk), 32'd3);

    // Duty boundaries.
    set_cfg(9, 0, 0, 0);
    wait_tick(20); cycle();
    count_run(20, h, tk);
    check("duty0_highs", 32'(h), 32'd0);
    set_cfg(9, 0, 0, 10);
    wait_tick(20); cycle();
    count_run(20, h, tk);
    check("duty_gt_p_highs", 32'(h), 32'd20);
    set_cfg(255, 0, 0, 255);
    wait_tick(20); cycle();
    count_run(256, h, tk);
    check("p255_d255_highs", 32'(h), 32'd255);
    check("p255_ticks", 32'(tk), 32'd1);

    // Mid-period config change is deferred to the boundary.
    set_cfg(9, 0, 0, 3);
    wait_tick(300);
    for (int i = 0; i < 4; i++) cycle();
    set_cfg(9, 0, 0, 7);
    check("pend_set", 32'(cfg_pending), 32'd1);
    wait_tick(20);
    check("pend_clr", 32'(cfg_pending), 32'd0);
    cycle();
    count_run(10, h, tk);
    check("shadow_d7_highs", 32'(h), 32'd7);

    // Center mode, prescale 1, P=4, duty0=2: 6 of 16 high.
    set_cfg(4, 1, 1, 2);
    wait_tick(30); cycle();
    count_run(32, h, tk);
    check("center_highs", 32'(h), 32'd12);
    check("center_ticks", 32'(tk), 32'd2);

    // Reset mid-period with a pending config.
    wait_tick(20);
    for (int i = 0; i < 3; i++) cycle();
    set_cfg(9, 0, 0, 5);
    check("pend_before_rst", 32'(cfg_pending), 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_mid_out", 32'(out), 32'd0);
    check("rst_mid_pend", 32'(cfg_pending), 32'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_default_duty", 32'(out), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) out_en = N_CH'($urandom);
      if ($urandom_range(0, 15) == 0) pwm_en = N_CH'($urandom);
      cfg_valid = ($urandom_range(0, 9) == 0);
      if (cfg_valid) begin
        period      = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom)
                                                   : CNT_W'($urandom_range(0, 12));
        prescale    = PRE_W'($urandom_range(0, 3));
        center_mode = 1'($urandom_range(0, 1));
        for (int c = 0; c < N_CH; c++)
          duty[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, int'(period) + 2));
      end
      cycle();
    end
    rst = 1'b0; cfg_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
